// File: rtl/mem_loader_pkg.sv
`timescale 1ns/1ps
// mem_loader_pkg
// Shared definitions for the memory loader: FSM state encodings, word geometry
// and the word-count clamp helper.
// Optional feature macro: LOADER_VERIFY_EN (adds the VERIFY and ERR states).
package mem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int MEM_WORDS      = 128;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

`ifdef LOADER_VERIFY_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;
`endif

    // A requested count of 0, or anything past the memory size, means "fill it all".
    function automatic logic [7:0] clamp_len(input logic [7:0] req);
        if (req == 8'd0 || req > 8'(MEM_WORDS)) begin
            return 8'(MEM_WORDS);
        end
        return req;
    endfunction

endpackage

// File: rtl/byte_packer.sv
`timescale 1ns/1ps
// byte_packer
// Shifts incoming bytes into a 32-bit word, most significant byte first.
// Ports:
//   CLK, RST_N  clock and asynchronous active-low reset
//   clear       restart packing at byte 0 with an empty word
//   shift_en    a byte transfers this cycle
//   byte_data   byte payload
//   word        packed word (valid once word_full has fired)
//   word_full   the byte transferring this cycle completes the word
module byte_packer
    import mem_loader_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    logic [1:0] byte_idx;

    // The index wraps back to 0 after the last byte, so a fresh word starts
    // without an explicit clear between words.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (shift_en) begin
            byte_idx <= byte_idx + 2'd1;
            word     <= {word[WORD_W-9:0], byte_data};
        end
    end

    // Combinational so the FSM can leave COLLECT on the same edge as the last byte.
    assign word_full = shift_en && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_loader.sv
`timescale 1ns/1ps
// mem_loader
// Bus initiator that fills program/data memory from a byte stream while the
// CPU is held in reset. Four bytes are packed into a word, written with one
// CS/WE cycle, and the address advances until the latched word count is met.
// Optional feature macro: LOADER_VERIFY_EN (read back each word; sticky err
// and an ERR state on mismatch).
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   start, len            begin a load of len words (0 or >128 means 128)
//   byte_valid/data/ready byte stream handshake
//   CS, WE, ADDR, Mem_Bus memory bus (Mem_Bus driven only while writing)
//   busy                  loader owns the memory bus
//   cpu_hold              keep the CPU in reset
//   done                  one-cycle completion pulse
//   err                   sticky readback mismatch
//   word_count            words written in the current or last load
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [7:0]        len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              CS,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Mem_Bus,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [7:0]        word_count
);

    state_t            state, state_nxt;
    logic [7:0]        len_q;
    logic [7:0]        count_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] packed_word;
    logic              word_full;
    logic              byte_fire;
    logic              start_load;
    logic              advance;

    // busy is low only in IDLE and ERR, the two states that accept a new start.
    assign start_load = start && !busy;
    assign byte_fire  = byte_valid && byte_ready;

    byte_packer u_packer (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .clear     (start_load),
        .shift_en  (byte_fire),
        .byte_data (byte_data),
        .word      (packed_word),
        .word_full (word_full)
    );

`ifdef LOADER_VERIFY_EN
    logic verify_bad;
    logic last_word;

    // count_q was already bumped by the WRITE that preceded VERIFY.
    assign verify_bad = (Mem_Bus != packed_word);
    assign last_word  = (count_q == len_q);
    assign advance    = (state == ST_VERIFY) && !verify_bad && !last_word;
`else
    logic last_word;

    assign last_word = ((count_q + 8'd1) == len_q);
    assign advance   = (state == ST_WRITE) && !last_word;
`endif

    // State register; reset drops the bus and releases the CPU at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_load) state_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (word_full) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
`ifdef LOADER_VERIFY_EN
                state_nxt = ST_VERIFY;
`else
                state_nxt = last_word ? ST_DONE : ST_COLLECT;
`endif
            end
`ifdef LOADER_VERIFY_EN
            ST_VERIFY: begin
                if (verify_bad)     state_nxt = ST_ERR;
                else if (last_word) state_nxt = ST_DONE;
                else                state_nxt = ST_COLLECT;
            end
            ST_ERR: begin
                if (start_load) state_nxt = ST_COLLECT;
            end
`endif
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Decoded outputs; ERR keeps the CPU held but gives the bus back.
    always_comb begin
        byte_ready = (state == ST_COLLECT);
        CS         = (state == ST_WRITE);
        WE         = (state == ST_WRITE);
        busy       = (state != ST_IDLE);
        cpu_hold   = (state != ST_IDLE);
        done       = (state == ST_DONE);
`ifdef LOADER_VERIFY_EN
        if (state == ST_VERIFY) CS   = 1'b1;
        if (state == ST_ERR)    busy = 1'b0;
`endif
    end

    // Load bookkeeping: length latch, word counter and address counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            len_q   <= '0;
            count_q <= '0;
            addr_q  <= '0;
        end else if (start_load) begin
            len_q   <= clamp_len(len);
            count_q <= '0;
            addr_q  <= '0;
        end else begin
            if (state == ST_WRITE) count_q <= count_q + 8'd1;
            if (advance)           addr_q  <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef LOADER_VERIFY_EN
    // Sticky mismatch flag, cleared only by the start of a new load.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err <= 1'b0;
        end else if (start_load) begin
            err <= 1'b0;
        end else if (state == ST_VERIFY && verify_bad) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    assign ADDR       = addr_q;
    assign word_count = count_q;
    assign Mem_Bus    = (state == ST_WRITE) ? packed_word : {DATA_W{1'bz}};

endmodule
